// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters.
// Optional grant statistics: define ALU_SHARE_STATS_EN.
module alu_share_arbiter #(
   parameter int               WIDTH   = 16,
   parameter int               OPW     = 3,
   parameter logic [OPW-1:0]   IDLE_OP = 3'b111
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [OPW-1:0]   req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [OPW-1:0]   req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OPW-1:0]   alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero
`ifdef ALU_SHARE_STATS_EN
   ,
   input  logic             stats_clr,
   output logic [15:0]      gnt0_count,
   output logic [15:0]      gnt1_count
`endif
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state, state_nxt;
   logic             last_grant;
   logic             gnt;
   logic             hs;
   logic [OPW-1:0]   op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic             id_q;

   // Contest goes to whoever did not win last time.
   always_comb begin
      gnt = 1'b0;
      if (req0_valid && req1_valid) gnt = ~last_grant;
      else if (req1_valid)          gnt = 1'b1;
   end

   assign req0_ready = (state == IDLE) && req0_valid && !gnt;
   assign req1_ready = (state == IDLE) && req1_valid && gnt;
   assign hs         = req0_ready || req1_ready;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (hs) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
         op_q       <= IDLE_OP;
         a_q        <= '0;
         b_q        <= '0;
         id_q       <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (hs) begin
                  op_q       <= gnt ? req1_op : req0_op;
                  a_q        <= gnt ? req1_a  : req0_a;
                  b_q        <= gnt ? req1_b  : req0_b;
                  id_q       <= gnt;
                  last_grant <= gnt;
               end
            end
            EXEC: begin
               rsp_result <= alu_result;
               rsp_zero   <= alu_zero;
               rsp_valid  <= 1'b1;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  op_q      <= IDLE_OP;
               end
            end
            default: ;
         endcase
      end
   end

   assign alu_a  = a_q;
   assign alu_b  = b_q;
   assign alu_op = op_q;
   assign rsp_id = id_q;

`ifdef ALU_SHARE_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt0_count <= '0;
         gnt1_count <= '0;
      end else if (stats_clr) begin
         gnt0_count <= '0;
         gnt1_count <= '0;
      end else begin
         if (req0_ready && gnt0_count != 16'hFFFF)
            gnt0_count <= gnt0_count + 16'd1;
         if (req1_ready && gnt1_count != 16'hFFFF)
            gnt1_count <= gnt1_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter.
// Stats checks compile in when ALU_SHARE_STATS_EN is defined.
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [2:0]  req0_op, req1_op;
   logic [15:0] req0_a, req0_b, req1_a, req1_b;
   logic [15:0] alu_a, alu_b, alu_result;
   logic [2:0]  alu_op;
   logic        alu_zero;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
   logic [15:0] rsp_result;
`ifdef ALU_SHARE_STATS_EN
   logic        stats_clr;
   logic [15:0] gnt0_count, gnt1_count;
`endif

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   alu_share_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_zero(rsp_zero)
`ifdef ALU_SHARE_STATS_EN
      ,
      .stats_clr(stats_clr),
      .gnt0_count(gnt0_count),
      .gnt1_count(gnt1_count)
`endif
   );

   // Reference ALU: op 100 is a compare (xor), 111 is idle.
   always_comb begin
      alu_result = 16'h0;
      case (alu_op)
         3'b000:  alu_result = alu_a + alu_b;
         3'b001:  alu_result = alu_a - alu_b;
         3'b010:  alu_result = alu_a & alu_b;
         3'b011:  alu_result = alu_a | alu_b;
         3'b100:  alu_result = alu_a ^ alu_b;
         default: alu_result = 16'h0;
      endcase
      alu_zero = (alu_result == 16'h0);
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h want %h", tag, obs, exp);
   endtask

   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

`ifdef ALU_SHARE_STATS_EN
   task automatic do_op(input bit id);
      bit got;
      got = 1'b0;
      if (id) req1_valid = 1'b1;
      else    req0_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #3;
         if ((id ? req1_ready : req0_ready) === 1'b1) begin
            got = 1'b1;
            break;
         end
         nxt;
      end
      chk("stats_op_ready", {31'b0, got}, 32'd1);
      nxt;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      nxt;
      nxt;
   endtask
`endif

   initial begin
      rst_n      = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_op    = 3'b000;
      req1_op    = 3'b000;
      req0_a     = 16'h0;
      req0_b     = 16'h0;
      req1_a     = 16'h0;
      req1_b     = 16'h0;
      rsp_ready  = 1'b1;
`ifdef ALU_SHARE_STATS_EN
      stats_clr  = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rsp", {rsp_valid, rsp_id, rsp_zero}, 3'b000);
      chk("rst_result", rsp_result, 16'h0);
      chk("rst_alu_op", alu_op, 3'b111);
      chk("rst_alu_a", alu_a, 16'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         #3;
         chk("idle_hold",
             {req0_ready, req1_ready, rsp_valid, alu_op},
             6'b000111);
         nxt;
      end

      // single request from requester 0
      req0_valid = 1'b1;
      req0_op    = 3'b000;
      req0_a     = 16'h0003;
      req0_b     = 16'h0004;
      #3;
      chk("single_ready", {req0_ready, req1_ready}, 2'b10);
      nxt;
      req0_valid = 1'b0;
      #3;
      chk("single_exec_op", alu_op, 3'b000);
      chk("single_exec_ab", {alu_a, alu_b}, 32'h0003_0004);
      chk("single_exec_rv", rsp_valid, 1'b0);
      nxt;
      #3;
      chk("single_rsp", {rsp_valid, rsp_zero, rsp_id}, 3'b100);
      chk("single_result", rsp_result, 16'h0007);
      nxt;
      #3;
      chk("single_done", {rsp_valid, alu_op}, 4'b0111);

      // both valid from reset
      nxt;
      rst_n      = 1'b0;
      req0_valid = 1'b1;
      req0_op    = 3'b100;
      req0_a     = 16'h1234;
      req0_b     = 16'h1234;
      req1_valid = 1'b1;
      req1_op    = 3'b100;
      req1_a     = 16'h0001;
      req1_b     = 16'h0002;
      nxt;
      rst_n = 1'b1;
      #3;
      chk("both_first", {req0_ready, req1_ready}, 2'b10);
      nxt;
      #3;
      chk("both_exec0", {req0_ready, req1_ready, alu_a}, 18'h01234);
      nxt;
      #3;
      chk("both_rsp0", {rsp_valid, rsp_id, rsp_zero}, 3'b101);
      chk("both_res0", rsp_result, 16'h0000);
      chk("both_rsp0_rdy", {req0_ready, req1_ready}, 2'b00);
      nxt;
      #3;
      chk("both_second", {req0_ready, req1_ready}, 2'b01);
      nxt;
      rsp_ready = 1'b0;
      #3;
      chk("both_exec1", {alu_a, alu_b}, 32'h0001_0002);
      nxt;

      // backpressure on requester 1's response
      for (int i = 0; i < 5; i++) begin
         #3;
         chk("bp_rsp", {rsp_valid, rsp_id, rsp_zero}, 3'b110);
         chk("bp_res", rsp_result, 16'h0003);
         chk("bp_rdy", {req0_ready, req1_ready}, 2'b00);
         nxt;
      end
      rsp_ready = 1'b1;
      #3;
      chk("bp_release", {rsp_valid, req0_ready, req1_ready}, 3'b100);
      nxt;
      #3;
      chk("bp_next_gnt", {req0_ready, req1_ready}, 2'b10);
      nxt;

      // reset during EXEC of a requester-0 operation
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      chk("mid_exec_op", alu_op, 3'b100);
      rst_n = 1'b0;
      #1;
      chk("mid_rst", {rsp_valid, alu_op}, 4'b0111);
      nxt;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #3;
         chk("post_rst_quiet", {rsp_valid, alu_op}, 4'b0111);
         nxt;
      end
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #3;
      chk("post_rst_gnt", {req0_ready, req1_ready}, 2'b10);
      nxt;

      // reset while a response is held drops rsp_valid at once
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      nxt;
      #3;
      chk("resp_before_rst", {rsp_valid, rsp_id, rsp_zero}, 3'b101);
      rst_n = 1'b0;
      #1;
      chk("resp_async_rst", {rsp_valid, rsp_zero}, 2'b00);
      nxt;
      rst_n = 1'b1;

`ifdef ALU_SHARE_STATS_EN
      nxt;
      chk("stats_rst", {gnt0_count, gnt1_count}, 32'h0);
      do_op(1'b0);
      do_op(1'b1);
      do_op(1'b0);
      do_op(1'b1);
      do_op(1'b0);
      chk("stats_gnt0", gnt0_count, 16'd3);
      chk("stats_gnt1", gnt1_count, 16'd2);
      req0_valid = 1'b1;
      stats_clr  = 1'b1;
      #3;
      chk("stats_clr_rdy", req0_ready, 1'b1);
      nxt;
      stats_clr  = 1'b0;
      req0_valid = 1'b0;
      chk("stats_clr", {gnt0_count, gnt1_count}, 32'h0);
      nxt;
      nxt;
`endif

      nxt;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 16-bit ALU between two requesters (e.g. main execute path and an address/branch-compare helper).
- Round-robin arbitration, valid/ready on each request port, registered response with requester id.
- Drives the ALU operand/opcode inputs from internal registers and samples the ALU result and zero outputs.
- Sits between the requesters and the ALU; contains no arithmetic itself.

Parameters:
- WIDTH, 16, operand/result width.
- OPW, 3, opcode width; the opcode is passed through to the ALU unmodified.
- IDLE_OP, 3'b111, opcode driven to the ALU when no operation is in flight; the ALU returns result 0 for it.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  OPW  requester 0 opcode
- req0_a  in  WIDTH  requester 0 operand a
- req0_b  in  WIDTH  requester 0 operand b
- req1_valid / req1_ready / req1_op / req1_a / req1_b: same as requester 0, for requester 1
- alu_a  out  WIDTH  to ALU operand a
- alu_b  out  WIDTH  to ALU operand b
- alu_op  out  OPW  to ALU opcode
- alu_result  in  WIDTH  from ALU
- alu_zero  in  1  from ALU
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes the response
- rsp_id  out  1  requester the response belongs to
- rsp_result  out  WIDTH  latched ALU result
- rsp_zero  out  1  latched ALU zero

Behaviour:
- Reset is asynchronous and active-low.
  - state=IDLE, last_grant=1 (so requester 0 wins the first contest).
  - Operand registers=0, op register=IDLE_OP.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0.
  - An in-flight operation is discarded on reset, and no response is produced.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - Grant select is combinational.
    - Only one valid: grant that requester.
    - Both valid: grant the requester != last_grant.
  - reqN_ready = (state==IDLE) && granted==N. It is 0 in every other state.
  - On a handshake (valid&&ready) the block:
    - latches op, a and b into the operand registers;
    - latches the requester index into the id register;
    - sets last_grant to that index;
    - moves to EXEC.
  - With no valid, the block stays in IDLE.
- EXEC: lasts one cycle.
  - alu_a, alu_b and alu_op are driven from the operand registers.
  - At the edge, alu_result and alu_zero are captured into rsp_result and rsp_zero, rsp_valid is set to 1, and the FSM moves to RESP.
- RESP:
  - rsp_* stays stable while rsp_valid=1 && rsp_ready=0.
  - On rsp_ready=1: rsp_valid is cleared, the FSM moves to IDLE, and the op register returns to IDLE_OP.
  - The next acceptance happens in the IDLE cycle after that, at the earliest.
- ALU drive:
  - alu_a, alu_b and alu_op always come from registers, never directly from the request ports.
  - Outside EXEC/RESP, alu_op=IDLE_OP.
- Latency and throughput:
  - Acceptance edge to rsp_valid=1 is 2 clk edges.
  - Best case is one operation per 3 cycles (IDLE, EXEC, RESP with rsp_ready held high).
- Requester rules:
  - A requester keeps valid, op, a and b stable until it sees ready.
  - Dropping valid before ready is legal, and no operation is issued for it.
- The zero flag is passed through exactly as the ALU produces it. It is only meaningful for opcode 3'b100; the block does no interpretation.
- Fairness: with both requesters valid continuously, grants strictly alternate 0,1,0,1…

Optional Feature:
- Macro: ALU_SHARE_STATS_EN.
- When defined, adds outputs gnt0_count and gnt1_count, each 16 bits.
  - Each counts that requester's handshakes.
  - Counts saturate at 16'hFFFF.
  - Counts reset to 0 on rst_n.
  - Also adds input stats_clr (1 bit): a synchronous clear that has priority over an increment in the same cycle.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset release, no valids: ready=0, rsp_valid=0, alu_op=3'b111 held for 10 cycles.
- Single request: req0 valid, op=000, a=16'h0003, b=16'h0004, rsp_ready=1. Required response: accepted at cycle N; rsp_valid=1 at N+2 with rsp_result=16'h0007, rsp_zero=0, rsp_id=0.
- Simultaneous requests: req0 and req1 valid from reset, both op=100, req0 a=b=16'h1234, req1 a=16'h1, b=16'h2. Required response: grant order 0 then 1; responses zero=1 (id 0), then zero=0 (id 1).
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid. Required response: rsp_result/rsp_id stable, req0_ready=req1_ready=0 throughout; the next grant comes only after rsp_ready=1.
- Reset mid-operation: assert rst_n=0 during EXEC. Required response: rsp_valid=0 immediately (asynchronous), state IDLE, no response after release, and the next contest is granted to requester 0.
- With ALU_SHARE_STATS_EN: 3 grants to req0 and 2 to req1 give gnt0_count=3 and gnt1_count=2; stats_clr asserted in the same cycle as a grant gives counts of 0.
